// File: rtl/sp_ram_pkg.sv
// Shared constants, index typedefs and address-split helpers for the banked RAM.
package sp_ram_pkg;

    localparam int unsigned BANK_SEL_LSB = 2;
    localparam int unsigned IDX_W        = 8;

    typedef logic [IDX_W-1:0] port_idx_t;
    typedef logic [IDX_W-1:0] bank_idx_t;

    function automatic bank_idx_t bank_index(input logic [31:0] addr, input int unsigned bank_bits);
        logic [31:0] mask;
        mask = (32'd1 << bank_bits) - 32'd1;
        return bank_idx_t'((addr >> BANK_SEL_LSB) & mask);
    endfunction

    function automatic logic [31:0] local_word(input logic [31:0] addr, input int unsigned bank_bits);
        return addr >> (BANK_SEL_LSB + bank_bits);
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM macro model; NUM_WORDS is the capacity in bytes.
module sp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS / (DATA_WIDTH / 8))
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned DEPTH = NUM_WORDS / (DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read-before-write: a write returns the old word, which callers treat as don't-care.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                    if (be_i[i]) begin
                        mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/sp_ram_bank_arb.sv
// Per-bank request arbiter: one-hot grant plus winner index.
// SP_RAM_RR_ARB_EN selects round-robin; otherwise fixed priority (lowest port wins).
module sp_ram_bank_arb #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
`ifdef SP_RAM_RR_ARB_EN
    input  logic                 clk,
`endif
    input  logic                 rstn_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PW-1:0]        win_o
);

    logic [NUM_PORTS-1:0] req_eff;
    logic                 found;

    // No grant can escape while reset is held, whatever the masters drive.
    assign req_eff = req_i & {NUM_PORTS{rstn_i}};

`ifdef SP_RAM_RR_ARB_EN
    logic [PW-1:0] last_q;
    logic [PW-1:0] cand;

    // Last winner resets to the top port so port 0 holds first priority.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= PW'(NUM_PORTS - 1);
        end else if (found) begin
            last_q <= win_o;
        end
    end

    always_comb begin
        found = 1'b0;
        win_o = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((32'(last_q) + i) % NUM_PORTS);
            if (!found && req_eff[cand]) begin
                found = 1'b1;
                win_o = cand;
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win_o = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (req_eff[i]) begin
                found = 1'b1;
                win_o = PW'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt_o = '0;
        if (found) begin
            gnt_o[win_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sp_ram_banked.sv
// Word-interleaved multi-port RAM: NUM_BANKS sp_ram banks, one arbiter per bank.
// Arbitration policy is chosen by SP_RAM_RR_ARB_EN (see sp_ram_bank_arb).
module sp_ram_banked
    import sp_ram_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i  [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i    [NUM_PORTS],
    input  logic [DATA_WIDTH-1:0]   wdata_i [NUM_PORTS],
    output logic [NUM_PORTS-1:0]    gnt_o,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o [NUM_PORTS]
);

    localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
    localparam int unsigned BSW        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned BANK_BYTES = RAM_SIZE / NUM_BANKS;
    localparam int unsigned WAW        = $clog2(BANK_BYTES / (DATA_WIDTH / 8));

    logic [BSW-1:0]        bank_sel   [NUM_PORTS];
    logic [WAW-1:0]        word_addr  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  bank_gnt   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [BSW-1:0]        bank_q     [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank_sel[p]  = BSW'(bank_index(32'(addr_i[p]), BANK_BITS));
            word_addr[p] = WAW'(local_word(32'(addr_i[p]), BANK_BITS));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0] req_l;
        logic [NUM_PORTS-1:0] gnt_l;
        logic [PW-1:0]        win_l;

        always_comb begin
            req_l = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req_l[p] = req_i[p] && (bank_sel[p] == BSW'(b));
            end
        end

        sp_ram_bank_arb #(
            .NUM_PORTS (NUM_PORTS),
            .PW        (PW)
        ) u_arb (
`ifdef SP_RAM_RR_ARB_EN
            .clk    (clk),
`endif
            .rstn_i (rstn_i),
            .req_i  (req_l),
            .gnt_o  (gnt_l),
            .win_o  (win_l)
        );

        sp_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WORDS  (BANK_BYTES),
            .ADDR_WIDTH (WAW)
        ) u_bank (
            .clk     (clk),
            .en_i    (|gnt_l),
            .we_i    (we_i[win_l]),
            .be_i    (be_i[win_l]),
            .addr_i  (word_addr[win_l]),
            .wdata_i (wdata_i[win_l]),
            .rdata_o (bank_rdata[b])
        );

        assign bank_gnt[b] = gnt_l;
    end

    // Each port requests at most one bank, so OR-ing the per-bank grants is exact.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                bank_q[p] <= '0;
            end
        end else begin
            rvalid_q <= gnt_o;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt_o[p]) begin
                    bank_q[p] <= bank_sel[p];
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_o[p] = rvalid_q[p] ? bank_rdata[bank_q[p]] : '0;
        end
    end

endmodule

// File: tb/tb_sp_ram_banked.sv
// Self-checking bench for sp_ram_banked: directed scenarios plus randomized traffic
// against a behavioural bank/arbitration model.
module tb_sp_ram_banked;

    localparam int NB = 4;
    localparam int NP = 2;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NP-1:0] req, we, gnt, rvalid;
    logic [AW-1:0] addr  [NP];
    logic [3:0]    be    [NP];
    logic [31:0]   wdata [NP];
    logic [31:0]   rdata [NP];

    always #5 clk = ~clk;

    sp_ram_banked dut (
        .clk      (clk),
        .rstn_i   (rstn),
        .req_i    (req),
        .addr_i   (addr),
        .we_i     (we),
        .be_i     (be),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [NP-1:0] gnt_s, rv_s;
    logic [31:0]   rd_s [NP];

    logic [31:0] mdl_mem [int];
    int          rr_last [NB];
    logic [31:0] exp_rd  [NP];
    logic [NP-1:0] exp_isrd;

    task automatic drive(input int p, input logic r, input logic [AW-1:0] a,
                         input logic w, input logic [3:0] b, input logic [31:0] d);
        req[p] = r; addr[p] = a; we[p] = w; be[p] = b; wdata[p] = d;
    endtask

    task automatic idle();
        req = '0;
        we  = '0;
    endtask

    // One clock: grant sampled mid-cycle, response sampled just after the edge.
    task automatic tick();
        @(negedge clk);
        gnt_s = gnt;
        @(posedge clk);
        #1;
        rv_s = rvalid;
        for (int p = 0; p < NP; p++) rd_s[p] = rdata[p];
    endtask

    function automatic int bank_of(input logic [AW-1:0] a);
        return (int'(a) / 4) % NB;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) old[8*i +: 8] = d[8*i +: 8];
        return old;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) rr_last[b] = NP - 1;
    endtask

    function automatic logic [NP-1:0] model_grant(input logic [NP-1:0] r);
        logic [NP-1:0] g;
        int best;
        g = '0;
        for (int b = 0; b < NB; b++) begin
            best = -1;
`ifdef SP_RAM_RR_ARB_EN
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (rr_last[b] + k) % NP;
                if (best < 0 && r[p] && bank_of(addr[p]) == b) best = p;
            end
`else
            for (int p = NP - 1; p >= 0; p--) begin
                if (r[p] && bank_of(addr[p]) == b) best = p;
            end
`endif
            if (best >= 0) begin
                g[best] = 1'b1;
                rr_last[b] = best;
            end
        end
        return g;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        drive(0, 1'b1, 15'h0, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 15'h4, 1'b0, 4'hF, 32'h0);
        #22;
        n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
        for (int p = 0; p < NP; p++) begin
            n_cmp++; if (rdata[p] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata%0d: got %h expected 0", p, rdata[p]); end
        end
        idle();
        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;
        model_reset();
    endtask

    task automatic test_rd_after_wr();
        drive(0, 1'b1, 15'h100, 1'b1, 4'hF, 32'hDEADBEEF);
        tick();
        n_cmp++; if (gnt_s !== 2'b01) begin n_fail++; $display("FAIL raw_wr_gnt: got %b expected 01", gnt_s); end
        n_cmp++; if (rv_s !== 2'b01) begin n_fail++; $display("FAIL raw_wr_rvalid: got %b expected 01", rv_s); end
        drive(0, 1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        n_cmp++; if (gnt_s !== 2'b01) begin n_fail++; $display("FAIL raw_rd_gnt: got %b expected 01", gnt_s); end
        n_cmp++; if (rv_s !== 2'b01) begin n_fail++; $display("FAIL raw_rd_rvalid: got %b expected 01", rv_s); end
        n_cmp++; if (rd_s[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_rdata: got %h expected deadbeef", rd_s[0]); end
        tick();
        n_cmp++; if (rv_s !== 2'b00) begin n_fail++; $display("FAIL raw_idle_rvalid: got %b expected 00", rv_s); end
    endtask

    task automatic test_byte_en();
        drive(0, 1'b1, 15'h40, 1'b1, 4'hF, 32'hFFFFFFFF);
        tick();
        drive(0, 1'b1, 15'h40, 1'b1, 4'b0101, 32'h00000000);
        tick();
        drive(0, 1'b1, 15'h40, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        n_cmp++; if (rv_s !== 2'b01) begin n_fail++; $display("FAIL be_rvalid: got %b expected 01", rv_s); end
        n_cmp++; if (rd_s[0] !== 32'hFF00FF00) begin n_fail++; $display("FAIL be_rdata: got %h expected ff00ff00", rd_s[0]); end
    endtask

    task automatic test_parallel();
        drive(0, 1'b1, 15'h0, 1'b1, 4'hF, 32'hA0A00001);
        drive(1, 1'b1, 15'h4, 1'b1, 4'hF, 32'hB1B10002);
        tick();
        n_cmp++; if (gnt_s !== 2'b11) begin n_fail++; $display("FAIL par_wr_gnt: got %b expected 11", gnt_s); end
        drive(0, 1'b1, 15'h0, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 15'h4, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        n_cmp++; if (gnt_s !== 2'b11) begin n_fail++; $display("FAIL par_rd_gnt: got %b expected 11", gnt_s); end
        n_cmp++; if (rv_s !== 2'b11) begin n_fail++; $display("FAIL par_rd_rvalid: got %b expected 11", rv_s); end
        n_cmp++; if (rd_s[0] !== 32'hA0A00001) begin n_fail++; $display("FAIL par_rdata0: got %h expected a0a00001", rd_s[0]); end
        n_cmp++; if (rd_s[1] !== 32'hB1B10002) begin n_fail++; $display("FAIL par_rdata1: got %h expected b1b10002", rd_s[1]); end
    endtask

    task automatic test_conflict();
        logic [NP-1:0] exp_g;
        logic [31:0]   d [NP];
        d[0] = 32'h0C0C0008;
        d[1] = 32'h1C1C0018;
        drive(1, 1'b1, 15'h8, 1'b1, 4'hF, d[0]);
        tick();
        drive(1, 1'b1, 15'h18, 1'b1, 4'hF, d[1]);
        tick();
        drive(0, 1'b1, 15'h8,  1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 15'h18, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef SP_RAM_RR_ARB_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            tick();
            n_cmp++; if (gnt_s !== exp_g) begin n_fail++; $display("FAIL conflict_gnt[%0d]: got %b expected %b", i, gnt_s, exp_g); end
            n_cmp++; if (rv_s !== exp_g) begin n_fail++; $display("FAIL conflict_rvalid[%0d]: got %b expected %b", i, rv_s, exp_g); end
            for (int p = 0; p < NP; p++) begin
                if (exp_g[p]) begin
                    n_cmp++; if (rd_s[p] !== d[p]) begin n_fail++; $display("FAIL conflict_rdata%0d[%0d]: got %h expected %h", p, i, rd_s[p], d[p]); end
                end else begin
                    n_cmp++; if (rd_s[p] !== 32'h0) begin n_fail++; $display("FAIL conflict_idle_rdata%0d[%0d]: got %h expected 0", p, i, rd_s[p]); end
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        drive(0, 1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
        tick();
        n_cmp++; if (rv_s !== 2'b01) begin n_fail++; $display("FAIL midrst_pre_rvalid: got %b expected 01", rv_s); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL midrst_rvalid: got %b expected 00", rvalid); end
        n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", rdata[0]); end
        n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 00", gnt); end
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;
        model_reset();
        drive(0, 1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        drive(1, 1'b1, 15'h40, 1'b0, 4'hF, 32'h0);
        n_cmp++; if (rd_s[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midrst_keep0: got %h expected deadbeef", rd_s[0]); end
        tick();
        idle();
        n_cmp++; if (rd_s[1] !== 32'hFF00FF00) begin n_fail++; $display("FAIL midrst_keep1: got %h expected ff00ff00", rd_s[1]); end
    endtask

    task automatic test_boundary();
        // Last word (bank 3) plus neighbours that would alias under a wrong bank/local split.
        drive(1, 1'b1, 15'h7FFC, 1'b1, 4'hF, 32'hC0FFEE11);
        drive(0, 1'b1, 15'h7FF8, 1'b1, 4'hF, 32'h22222222);
        tick();
        n_cmp++; if (gnt_s !== 2'b11) begin n_fail++; $display("FAIL top_wr_gnt: got %b expected 11", gnt_s); end
        idle();
        drive(0, 1'b1, 15'h7FEC, 1'b1, 4'hF, 32'h33333333);
        tick();
        drive(0, 1'b1, 15'h000C, 1'b1, 4'hF, 32'h44444444);
        tick();
        drive(1, 1'b1, 15'h7FFC, 1'b0, 4'hF, 32'h0);
        drive(0, 1'b1, 15'h7FF8, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        n_cmp++; if (gnt_s !== 2'b11) begin n_fail++; $display("FAIL top_rd_gnt: got %b expected 11", gnt_s); end
        n_cmp++; if (rd_s[1] !== 32'hC0FFEE11) begin n_fail++; $display("FAIL top_last_word: got %h expected c0ffee11", rd_s[1]); end
        n_cmp++; if (rd_s[0] !== 32'h22222222) begin n_fail++; $display("FAIL top_bank2_word: got %h expected 22222222", rd_s[0]); end
        drive(0, 1'b1, 15'h7FEC, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        n_cmp++; if (rd_s[0] !== 32'h33333333) begin n_fail++; $display("FAIL top_prev_local: got %h expected 33333333", rd_s[0]); end
        drive(1, 1'b1, 15'h000C, 1'b0, 4'hF, 32'h0);
        tick();
        idle();
        n_cmp++; if (rd_s[1] !== 32'h44444444) begin n_fail++; $display("FAIL top_local0: got %h expected 44444444", rd_s[1]); end
    endtask

    task automatic test_random();
        logic [NP-1:0] exp_g;
        logic [NP-1:0] pend;
        int w;
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            drive(0, 1'b1, AW'(i * 4), 1'b1, 4'hF, $urandom);
            exp_g = model_grant(req);
            mdl_mem[i] = wdata[0];
            tick();
            n_cmp++; if (gnt_s !== exp_g) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %b expected %b", i, gnt_s, exp_g); end
        end
        idle();
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        drive(p, 1'b1, AW'($urandom_range(0, 31) * 4), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), $urandom);
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
            exp_g = model_grant(req);
            exp_isrd = '0;
            for (int p = 0; p < NP; p++) begin
                if (exp_g[p]) begin
                    w = int'(addr[p]) / 4;
                    if (we[p]) mdl_mem[w] = merge(mdl_mem[w], wdata[p], be[p]);
                    else begin exp_isrd[p] = 1'b1; exp_rd[p] = mdl_mem[w]; end
                end
            end
            tick();
            n_cmp++; if (gnt_s !== exp_g) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt_s, exp_g); end
            n_cmp++; if (rv_s !== exp_g) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, rv_s, exp_g); end
            for (int p = 0; p < NP; p++) begin
                if (exp_isrd[p]) begin
                    n_cmp++; if (rd_s[p] !== exp_rd[p]) begin n_fail++; $display("FAIL rnd_rdata%0d[%0d]: got %h expected %h", p, c, rd_s[p], exp_rd[p]); end
                end else if (!exp_g[p]) begin
                    n_cmp++; if (rd_s[p] !== 32'h0) begin n_fail++; $display("FAIL rnd_idle_rdata%0d[%0d]: got %h expected 0", p, c, rd_s[p]); end
                end
            end
            pend = req & ~exp_g;
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            addr[p] = '0; be[p] = '0; wdata[p] = '0;
        end
        idle();
        test_reset();
        test_rd_after_wr();
        test_byte_en();
        test_parallel();
        test_conflict();
        test_reset_midop();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_banked.md
# sp_ram_banked

Multi-port, word-interleaved banked RAM for the PULPino memory subsystem, successor to the single-port RAM wrapper. Splits `RAM_SIZE` bytes into `NUM_BANKS` single-port `sp_ram` banks and serves `NUM_PORTS` masters (e.g. instruction fetch and LSU) concurrently. Masters use the core's req/gnt/rvalid protocol. Per-bank arbitration resolves conflicts, so masters hitting different banks proceed in the same cycle.

## Interface
- `RAM_SIZE`, 32768, total bytes; power of two
- `NUM_BANKS`, 4, bank count; power of two, ≥1
- `NUM_PORTS`, 2, master count, ≥1
- `DATA_WIDTH`, 32, word width
- `ADDR_WIDTH`, `$clog2(RAM_SIZE)`, byte address width
- `clk` in 1: the single clock
- `rstn_i` in 1: asynchronous, active-low reset
- `req_i` in [NUM_PORTS]: request per port
- `addr_i` in [NUM_PORTS][ADDR_WIDTH]: byte address; bits [1:0] ignored
- `we_i` in [NUM_PORTS]: 1 = write
- `be_i` in [NUM_PORTS][DATA_WIDTH/8]: byte enables, write only
- `wdata_i` in [NUM_PORTS][DATA_WIDTH]: write data
- `gnt_o` out [NUM_PORTS]: request accepted this cycle
- `rvalid_o` out [NUM_PORTS]: response valid, for reads and writes
- `rdata_o` out [NUM_PORTS][DATA_WIDTH]: read data, qualified by `rvalid_o`

## Operation
- Bank select is `addr_i[2 +: log2(NUM_BANKS)]`. Bank-local word address is `addr_i[ADDR_WIDTH-1 : 2+log2(NUM_BANKS)]`. Consecutive words therefore go to consecutive banks.
- Each bank has one arbiter.
  - Candidates are the ports with `req_i` set that target that bank.
  - Exactly one candidate is granted per cycle.
  - The bank macro sees `en = granted` and the winning port's `we`/`be`/`wdata`/address.
- `gnt_o[p]` is combinational from `req_i` and arbiter state.
  - A port that is not granted holds its request unchanged until granted.
  - The block must not depend on this.
- Response tracking: per port, registered `rvalid_q[p]` and `bank_q[p]`, captured when `gnt_o[p]` is set.
- `rdata_o[p]` is the `rdata` of bank `bank_q[p]` when `rvalid_q[p]` is set, otherwise 0.
- A write returns `rvalid` with `rdata_o` equal to the bank's output, which is don't-care.
- `NUM_BANKS=1` degenerates to a single shared bank with no bank-select bits.

## Timing
- A grant in cycle N produces `rvalid_o` in cycle N+1 with data. Throughput is one access per port per cycle when there is no conflict.
- Back-to-back grants to the same port give `rvalid_o` in consecutive cycles.
- Reset values:
  - `rvalid_o` = 0, `rdata_o` = 0.
  - Arbiter pointers = port 0.
  - `gnt_o` = 0 while `rstn_i` is low, regardless of `req_i`.
- Reset asserted mid-operation: outstanding responses are discarded, and `rvalid_o` drops asynchronously. RAM contents are unchanged.
- Read and write to the same bank and address by different ports in one cycle: only the winner is executed. The loser completes in a later cycle and sees the post-write data.

## Configuration
- `SP_RAM_RR_ARB_EN`, defined: round-robin arbitration.
  - Each bank keeps a `log2(NUM_PORTS)`-bit last-winner register.
  - On any grant in that bank it updates to the winning port.
  - Priority starts at last-winner+1 and wraps from `NUM_PORTS-1` to 0.
  - Any persistently requesting port is granted within `NUM_PORTS` cycles.
- `SP_RAM_RR_ARB_EN`, undefined: fixed priority, lowest port index wins. No arbiter state is kept, and starvation of higher ports is permitted.

## Structure
- `sp_ram_pkg` holds:
  - the `BANK_SEL_LSB = 2` constant;
  - functions for bank index and local address derivation;
  - the `port_idx_t`/`bank_idx_t` typedef widths.
- Sub-module `sp_ram_bank_arb`, one instance per bank. It takes the request vector and provides the one-hot grant plus the winner index, and contains the `SP_RAM_RR_ARB_EN` logic.
- Banks are `sp_ram` instances with `NUM_WORDS = RAM_SIZE/NUM_BANKS` bytes.

## Test plan
- **Single-port read after write:** port0 writes 0xDEADBEEF at 0x100, then reads 0x100. Expect `gnt` in the same cycle, `rvalid` one cycle later, `rdata` = 0xDEADBEEF.
- **Byte enables:** write 0xFFFFFFFF to 0x40, then write 0x00000000 with `be=4'b0101`, then read. Expect `rdata` = 0xFF00FF00.
- **Parallel access:** port0 reads 0x0 (bank0) and port1 reads 0x4 (bank1) in the same cycle. Both are granted, and both get `rvalid` in the next cycle with correct data.
- **Conflict:** both ports hold reads to bank2 for 4 cycles.
  - With `SP_RAM_RR_ARB_EN`: grants alternate 0,1,0,1.
  - Without it: port0 is granted every cycle and port1 is never granted.
- **Reset mid-op:** assert `rstn_i` low in the cycle after a grant. Expect `rvalid_o` = 0 and `rdata_o` = 0 immediately. After release, earlier-written data reads back intact.
- **Wrap/boundary:** access the last word `RAM_SIZE-4` from port1. Expect correct bank (`NUM_BANKS-1`), correct local address, and correct data.
